mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single mem_* port (read/write/byte_enable/address/wdata, rdata/resp)
//  between an instruction-fetch requester (read-only) and a data requester (R/W).
//  Sits between the CPU-side requesters (control/datapath or I/D caches) and
//  physical memory. One transaction in flight at a time.
//  Fixed data-first priority, with a starvation guard for fetch.
// PARAMETERS
//  D_BURST_MAX  4  max consecutive D grants while I is pending before I is forced (>=1)
// PORTS
//  clk               in   1   clock, all state updates on rising edge
//  rst               in   1   synchronous reset, active-high
//  imem_read         in   1   I request (held until imem_resp)
//  imem_address      in   32  I address
//  imem_rdata        out  32  I read data, valid with imem_resp
//  imem_resp         out  1   I completion pulse (1 cycle)
//  dmem_read         in   1   D read request (held until dmem_resp)
//  dmem_write        in   1   D write request (held until dmem_resp)
//  dmem_byte_enable  in   4   D write byte mask
//  dmem_address      in   32  D address
//  dmem_wdata        in   32  D write data
//  dmem_rdata        out  32  D read data, valid with dmem_resp
//  dmem_resp         out  1   D completion pulse (1 cycle)
//  mem_read          out  1   downstream read strobe
//  mem_write         out  1   downstream write strobe
//  mem_byte_enable   out  4   downstream byte mask
//  mem_address       out  32  downstream address
//  mem_wdata         out  32  downstream write data
//  mem_rdata         in   32  downstream read data
//  mem_resp          in   1   downstream completion pulse
// BEHAVIOUR
//  Reset: state=IDLE, d_streak=0; mem_read=mem_write=0, mem_byte_enable=4'h0,
//   mem_address=mem_wdata=0; imem_resp=dmem_resp=0. Reset mid-transaction
//   abandons it; no resp is issued; downstream is reset in the same cycle.
//  States: IDLE, SERVE_I, SERVE_D.
//  IDLE: evaluated each cycle on the request inputs.
//   - D pending (dmem_read|dmem_write) and (!imem_read or d_streak<D_BURST_MAX)
//     -> SERVE_D.
//   - Else imem_read -> SERVE_I.
//   - Else stay in IDLE.
//  Grant edge (IDLE->SERVE_x): the winner's address/wdata/byte_enable/op are
//   registered into the mem_* outputs. Strobe rises the cycle after the request
//   is seen (1-cycle grant latency). mem_* stay stable for the whole transaction.
//  I grant: mem_read=1, mem_write=0, mem_byte_enable=4'hF, mem_wdata=0.
//  D read: mem_byte_enable=4'hF. D write: byte_enable and wdata are passed as given.
//  d_streak on a D grant: +1 if imem_read was high, else cleared to 0. It saturates
//   at D_BURST_MAX. It clears to 0 on every I grant.
//   Width is $clog2(D_BURST_MAX+1).
//  SERVE_x: waits for mem_resp. In the mem_resp cycle:
//   - x_resp=1 combinationally, in the same cycle.
//   - x_rdata=mem_rdata.
//   - Next state is IDLE.
//   - mem_read/mem_write are cleared at that edge, so strobes drop the cycle after resp.
//  rdata outputs pass mem_rdata through in all states. They are meaningful only with resp.
//  Non-granted resp is 0 in all cycles.
//  Back-to-back: min gap of 1 IDLE cycle between transactions (resp at M, next
//   strobe at M+2). A request seen in IDLE is always treated as new. Requesters
//   must drop or replace their request the cycle after their resp.
//  mem_resp while IDLE: ignored, no resp forwarded, no state change.
//  Request deasserted during SERVE_x: illegal. The transaction still completes
//   downstream and resp is still pulsed.
//  dmem_read&&dmem_write together: illegal. Bench asserts on it. RTL treats it as a write.
// TESTING
//  1 rst high 2 cycles -> all mem_* = 0, both resp=0, state IDLE.
//  2 imem_read @0x60, mem_resp 3 cycles after strobe ->
//    - mem_read rises next cycle with addr 0x60, be=F;
//    - imem_resp=1 with rdata echoed;
//    - strobe low the cycle after.
//  3 imem_read and dmem_write (addr 0x100, be=4'b0011, wdata 0xDEADBEEF) rise together ->
//    - D is served first, with mem_write=1 and exact be/wdata;
//    - then I is served (strobe 2 cycles after dmem_resp).
//  4 imem_read held, D requests back-to-back 6 times, D_BURST_MAX=4 ->
//    grant order D,D,D,D,I,D,D; d_streak returns to 0 after I.
//  5 rst asserted mid SERVE_D ->
//    - next cycle all outputs are 0;
//    - a late mem_resp while IDLE produces no dmem_resp/imem_resp.
//  6 mem_resp pulsed while IDLE with no requests -> no resp, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port shared by an I-fetch and a data requester
//
// Purpose: grants the downstream mem_* port to one requester at a time.
//   Data wins by default. Fetch is forced through after D_BURST_MAX
//   consecutive data grants that were made while fetch was waiting.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_*            fetch side: read, address in; rdata, resp out
//   dmem_*            data side: read, write, byte_enable, address, wdata in; rdata, resp out
//   mem_*             downstream: read, write, byte_enable, address, wdata out; rdata, resp in
module mem_port_arbiter #(
  parameter int D_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_read,
  input  logic [31:0] imem_address,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int SW = $clog2(D_BURST_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(D_BURST_MAX);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t        state;
  logic [SW-1:0] d_streak;
  logic          d_pend;
  logic          d_win;

  assign d_pend = dmem_read | dmem_write;
  // Data keeps priority unless fetch is waiting and data already used its burst.
  assign d_win  = d_pend && (!imem_read || (d_streak < STREAK_MAX));

  // Responses are forwarded in the same cycle as mem_resp, only to the owner.
  assign imem_resp  = (state == SERVE_I) && mem_resp;
  assign dmem_resp  = (state == SERVE_D) && mem_resp;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      d_streak        <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= 4'h0;
      mem_address     <= '0;
      mem_wdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_win) begin
            state       <= SERVE_D;
            // Simultaneous read and write is treated as a write.
            mem_read        <= !dmem_write;
            mem_write       <= dmem_write;
            mem_byte_enable <= dmem_write ? dmem_byte_enable : 4'hF;
            mem_address     <= dmem_address;
            mem_wdata       <= dmem_write ? dmem_wdata : '0;
            // Streak only counts grants that made fetch wait.
            if (!imem_read)
              d_streak <= '0;
            else if (d_streak != STREAK_MAX)
              d_streak <= d_streak + SW'(1);
          end else if (imem_read) begin
            state           <= SERVE_I;
            mem_read        <= 1'b1;
            mem_write       <= 1'b0;
            mem_byte_enable <= 4'hF;
            mem_address     <= imem_address;
            mem_wdata       <= '0;
            d_streak        <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_read = 1'b0;
  logic [31:0] imem_address = '0;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        dmem_read = 1'b0;
  logic        dmem_write = 1'b0;
  logic [3:0]  dmem_byte_enable = '0;
  logic [31:0] dmem_address = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;

  mem_port_arbiter #(.D_BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    assert (rst || !(dmem_read && dmem_write))
      else $error("illegal: dmem_read and dmem_write together");

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  int total = 0;
  int bad = 0;
  logic [31:0] q_i[$];
  logic [31:0] q_d[$];

  typedef struct {
    logic rd; logic wr; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic ir; logic dr; logic dw; logic [3:0] be; logic [31:0] addr;
    logic [31:0] wdata; int lat;
    logic exp_rd; logic exp_wr; logic [3:0] exp_be; logic [31:0] exp_wdata;
  } vec_t;

  function automatic logic [31:0] mdl(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
  endtask

  // Downstream responder: waits for a strobe, holds lat cycles, pulses mem_resp,
  // and scores the forwarded response against the per-port scoreboard queue.
  task automatic serve(input int lat, output logic got_d, output int waited, output grant_t g);
    int n;
    n = 0;
    got_d = 1'b0;
    while (!(mem_read || mem_write) && n < 40) begin
      tick();
      n++;
    end
    waited = n;
    g.rd = mem_read; g.wr = mem_write; g.be = mem_byte_enable;
    g.addr = mem_address; g.wdata = mem_wdata;
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL strobe_timeout: got no strobe want strobe within 40 cycles");
      return;
    end
    for (int k = 0; k < lat; k++) begin
      chk("resp_early", {30'd0, imem_resp, dmem_resp}, 32'd0);
      tick();
    end
    chk("held_addr", mem_address, g.addr);
    chk("held_strobe", {30'd0, mem_read, mem_write}, {30'd0, g.rd, g.wr});
    mem_rdata = mdl(mem_address);
    mem_resp = 1'b1;
    #1;
    got_d = dmem_resp;
    total++;
    if (imem_resp == dmem_resp) begin
      bad++;
      $display("FAIL resp_onehot: got i=%0b d=%0b want exactly one", imem_resp, dmem_resp);
    end else if (dmem_resp) begin
      if (q_d.size() == 0) begin
        bad++;
        $display("FAIL d_unexpected: got dmem_resp want none");
      end else chk("d_rdata", dmem_rdata, q_d.pop_front());
    end else begin
      if (q_i.size() == 0) begin
        bad++;
        $display("FAIL i_unexpected: got imem_resp want none");
      end else chk("i_rdata", imem_rdata, q_i.pop_front());
    end
    tick();
    mem_resp = 1'b0;
    mem_rdata = '0;
    chk("strobe_drop", {30'd0, mem_read, mem_write}, 32'd0);
  endtask

  vec_t   vt[5];
  int     exp_ord[7];
  logic   got_d;
  int     waited;
  int     dcount;
  grant_t g;

  initial begin
    // ir dr dw be addr wdata lat | exp rd wr be wdata
    vt[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_0060, 32'h7777_7777, 3, 1'b1, 1'b0, 4'hF, 32'h0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 4'h5, 32'h0000_0200, 32'h0,         1, 1'b1, 1'b0, 4'hF, 32'h0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 2, 1'b0, 1'b1, 4'h3, 32'hDEAD_BEEF};
    vt[3] = '{1'b0, 1'b0, 1'b1, 4'h8, 32'h0000_03FC, 32'h1234_5678, 0, 1'b0, 1'b1, 4'h8, 32'h1234_5678};
    vt[4] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 5, 1'b1, 1'b0, 4'hF, 32'h0};
    exp_ord = '{1, 1, 1, 1, 0, 1, 1};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_be", {28'd0, mem_byte_enable}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_resp", {30'd0, imem_resp, dmem_resp}, 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    rst = 1'b0;
    tick();

    // Single-requester transactions from the table
    for (int i = 0; i < 5; i++) begin
      imem_read        = vt[i].ir;
      imem_address     = vt[i].ir ? vt[i].addr : 32'h0BAD_0000;
      dmem_read        = vt[i].dr;
      dmem_write       = vt[i].dw;
      dmem_address     = (vt[i].dr || vt[i].dw) ? vt[i].addr : 32'h0BAD_1111;
      dmem_byte_enable = vt[i].be;
      dmem_wdata       = vt[i].wdata;
      if (vt[i].ir) q_i.push_back(mdl(vt[i].addr));
      else          q_d.push_back(mdl(vt[i].addr));
      serve(vt[i].lat, got_d, waited, g);
      drop_all();
      chk("t_latency", 32'(waited), 32'd1);
      chk("t_port", {31'd0, got_d}, {31'd0, vt[i].dr | vt[i].dw});
      chk("t_rd", {31'd0, g.rd}, {31'd0, vt[i].exp_rd});
      chk("t_wr", {31'd0, g.wr}, {31'd0, vt[i].exp_wr});
      chk("t_be", {28'd0, g.be}, {28'd0, vt[i].exp_be});
      chk("t_addr", g.addr, vt[i].addr);
      chk("t_wdata", g.wdata, vt[i].exp_wdata);
    end

    // I and D write arrive together: D first, then I two cycles after dmem_resp
    imem_read = 1'b1; imem_address = 32'h0000_0060; q_i.push_back(mdl(32'h60));
    dmem_write = 1'b1; dmem_address = 32'h0000_0100; dmem_byte_enable = 4'b0011;
    dmem_wdata = 32'hDEAD_BEEF; q_d.push_back(mdl(32'h100));
    serve(2, got_d, waited, g);
    dmem_write = 1'b0;
    chk("pri_d_first", {31'd0, got_d}, 32'd1);
    chk("pri_d_wr", {31'd0, g.wr}, 32'd1);
    chk("pri_d_be", {28'd0, g.be}, 32'h3);
    chk("pri_d_wdata", g.wdata, 32'hDEAD_BEEF);
    serve(1, got_d, waited, g);
    imem_read = 1'b0;
    chk("pri_i_second", {31'd0, got_d}, 32'd0);
    chk("pri_i_gap", 32'(waited), 32'd1);
    chk("pri_i_addr", g.addr, 32'h60);

    // Starvation guard: I held, six back-to-back D requests
    imem_read = 1'b1; imem_address = 32'h0000_0400; q_i.push_back(mdl(32'h400));
    dmem_read = 1'b1; dmem_address = 32'h0000_0800; q_d.push_back(mdl(32'h800));
    dcount = 0;
    for (int k = 0; k < 7; k++) begin
      serve(1, got_d, waited, g);
      chk("burst_order", {31'd0, got_d}, 32'(exp_ord[k]));
      chk("burst_gap", 32'(waited), 32'd1);
      if (got_d) begin
        dcount++;
        if (dcount < 6) begin
          dmem_address = 32'h0000_0800 + 32'(dcount * 4);
          dmem_read  = (dcount % 2) == 0;
          dmem_write = (dcount % 2) == 1;
          dmem_byte_enable = 4'hC;
          dmem_wdata = 32'(dcount);
          q_d.push_back(mdl(dmem_address));
        end else begin
          dmem_read = 1'b0; dmem_write = 1'b0;
        end
      end else begin
        imem_read = 1'b0;
        chk("streak_after_i", 32'(dut.d_streak), 32'd0);
      end
    end
    chk("burst_q_empty", 32'(q_i.size() + q_d.size()), 32'd0);

    // Stray mem_resp while idle
    mem_resp = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    chk("idle_resp", {30'd0, imem_resp, dmem_resp}, 32'd0);
    tick();
    mem_resp = 1'b0;
    chk("idle_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("idle_state", 32'(dut.state), 32'd0);

    // Reset in the middle of a D read
    dmem_read = 1'b1; dmem_address = 32'h0000_0900;
    tick();
    chk("mid_strobe", {31'd0, mem_read}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("mid_rst_addr", mem_address, 32'd0);
    chk("mid_rst_be", {28'd0, mem_byte_enable}, 32'd0);
    rst = 1'b0;
    dmem_read = 1'b0;
    mem_resp = 1'b1; mem_rdata = 32'h1111_2222;
    #1;
    chk("late_resp", {30'd0, imem_resp, dmem_resp}, 32'd0);
    tick();
    mem_resp = 1'b0;
    chk("late_strobes", {30'd0, mem_read, mem_write}, 32'd0);

    // Recovery transaction after reset
    imem_read = 1'b1; imem_address = 32'h0000_0A00; q_i.push_back(mdl(32'hA00));
    serve(2, got_d, waited, g);
    imem_read = 1'b0;
    chk("recover_port", {31'd0, got_d}, 32'd0);
    chk("recover_latency", 32'(waited), 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
